systolic_feeder: RTL and testbench

Front-end sequencer that drives the weight and activation inputs of the weight-stationary systolic array.
- Accepts weight rows and activation vectors from upstream buffers over valid/ready handshakes.
- Runs the weight-load phase (write_weight_en pulses).
- Skews activations so array row i sees its element i cycles after row 0.
- Flushes zeros so the last partial sums exit through out_sum, then pulses done.

---
 rtl/systolic_feeder.sv | 158 +++++++++++++++
 tb/tb_systolic_feeder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Front-end sequencer for the weight-stationary systolic array:
// loads weight rows, skews activation vectors, drains with zeros, pulses done.
module systolic_feeder #(
    parameter int DATASIZE    = 8,
    parameter int ARRAYWIDTH  = 4,
    parameter int ARRAYHEIGHT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic [DATASIZE*ARRAYWIDTH-1:0]  w_data,
    input  logic                            a_valid,
    output logic                            a_ready,
    input  logic [DATASIZE*ARRAYHEIGHT-1:0] a_data,
    input  logic                            a_last,
    output logic                            write_weight_en,
    output logic [DATASIZE*ARRAYWIDTH-1:0]  out_up_weight,
    output logic [DATASIZE*ARRAYHEIGHT-1:0] out_left_act,
    output logic                            busy,
    output logic                            done
);

    localparam int WCW       = (ARRAYHEIGHT > 1) ? $clog2(ARRAYHEIGHT) : 1;
    localparam int DRAIN_LEN = ARRAYHEIGHT + ARRAYWIDTH;
    localparam int DCW       = $clog2(DRAIN_LEN);

    localparam logic [WCW-1:0] W_LAST = WCW'(ARRAYHEIGHT - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN
    } state_t;

    state_t                          state_q, state_d;
    logic [WCW-1:0]                  w_cnt_q, w_cnt_d;
    logic [DCW-1:0]                  d_cnt_q, d_cnt_d;
    logic                            wwe_q, wwe_d;
    logic [DATASIZE*ARRAYWIDTH-1:0]  up_q, up_d;
    logic                            done_q, done_d;

    logic w_hs;
    logic a_hs;
    logic shift_en;

    assign w_ready  = (state_q == LOAD_W);
    assign a_ready  = (state_q == STREAM);
    assign busy     = (state_q != IDLE);
    assign shift_en = (state_q == STREAM) || (state_q == DRAIN);

    assign w_hs = w_valid && w_ready;
    assign a_hs = a_valid && a_ready;

    assign write_weight_en = wwe_q;
    assign out_up_weight   = up_q;
    assign done            = done_q;

    always_comb begin
        state_d = state_q;
        w_cnt_d = w_cnt_q;
        d_cnt_d = d_cnt_q;
        wwe_d   = 1'b0;
        up_d    = up_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    w_cnt_d = '0;
                end
            end
            LOAD_W: begin
                if (w_hs) begin
                    wwe_d = 1'b1;
                    up_d  = w_data;
                    if (w_cnt_q == W_LAST) begin
                        state_d = STREAM;
                        w_cnt_d = '0;
                    end else begin
                        w_cnt_d = w_cnt_q + WCW'(1);
                    end
                end
            end
            STREAM: begin
                if (a_hs && a_last) begin
                    state_d = DRAIN;
                    d_cnt_d = D_LAST;
                end
            end
            DRAIN: begin
                // Long enough for the last activation to reach the bottom
                // row and its partial sum to cross every column.
                if (d_cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    d_cnt_d = d_cnt_q - DCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_cnt_q <= '0;
            d_cnt_q <= '0;
            wwe_q   <= 1'b0;
            up_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_cnt_q <= w_cnt_d;
            d_cnt_q <= d_cnt_d;
            wwe_q   <= wwe_d;
            up_q    <= up_d;
            done_q  <= done_d;
        end
    end

    // Lane i owns i+1 registers so its element lags row 0 by i cycles.
    for (genvar i = 0; i < ARRAYHEIGHT; i++) begin : g_lane
        logic [DATASIZE-1:0] line_q [i+1];
        logic [DATASIZE-1:0] line_d [i+1];

        always_comb begin
            for (int k = 0; k <= i; k++) begin
                line_d[k] = line_q[k];
            end
            if (shift_en) begin
                line_d[0] = a_hs ? a_data[i*DATASIZE +: DATASIZE] : '0;
                for (int k = 1; k <= i; k++) begin
                    line_d[k] = line_q[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) begin
                    line_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k <= i; k++) begin
                    line_q[k] <= line_d[k];
                end
            end
        end

        assign out_left_act[i*DATASIZE +: DATASIZE] = line_q[i];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed vector table plus a hand-written job for systolic_feeder.
// Each table row: outputs expected this cycle, inputs driven this cycle.
module tb_systolic_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        a_last;
    logic        write_weight_en;
    logic [31:0] out_up_weight;
    logic [31:0] out_left_act;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        rst;
        logic        start;
        logic        wv;
        logic [31:0] wd;
        logic        av;
        logic [31:0] ad;
        logic        al;
        logic        wr;
        logic        ar;
        logic        bz;
        logic        dn;
        logic        we;
        logic [31:0] upw;
        logic [31:0] left;
    } vec_t;

    vec_t tbl[$];

    systolic_feeder #(
        .DATASIZE(8),
        .ARRAYWIDTH(4),
        .ARRAYHEIGHT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .w_data(w_data),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_data(a_data),
        .a_last(a_last),
        .write_weight_en(write_weight_en),
        .out_up_weight(out_up_weight),
        .out_left_act(out_left_act),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic void add(
        input logic r, input logic s,
        input logic wv, input logic [31:0] wd,
        input logic av, input logic [31:0] ad, input logic al,
        input logic wr, input logic ar, input logic bz,
        input logic dn, input logic we,
        input logic [31:0] upw, input logic [31:0] left
    );
        vec_t v;
        v.rst = r; v.start = s; v.wv = wv; v.wd = wd;
        v.av = av; v.ad = ad; v.al = al;
        v.wr = wr; v.ar = ar; v.bz = bz; v.dn = dn; v.we = we;
        v.upw = upw; v.left = left;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [68:0] exp_v);
        logic [68:0] got;
        got = {w_ready, a_ready, busy, done, write_weight_en,
               out_up_weight, out_left_act};
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got rdy/ar/busy/done/we=%b%b%b%b%b up=%h left=%h, want %b%b%b%b%b up=%h left=%h",
                     name, got[68], got[67], got[66], got[65], got[64],
                     got[63:32], got[31:0], exp_v[68], exp_v[67],
                     exp_v[66], exp_v[65], exp_v[64],
                     exp_v[63:32], exp_v[31:0]);
        end
    endtask

    localparam logic [31:0] P = 32'h100F0E0D;
    localparam logic [31:0] Q = 32'h04040404;
    localparam logic [31:0] R = 32'hD0D0D0D0;

    initial begin
        logic [31:0] wd_last;
        logic [31:0] ad_rand;
        int          n;
        bit          got_done;

        // weight load with a gap; ignored a_valid/start/w_valid
        add(0,1,1,32'hDEADBEEF,1,32'h55667788,1, 0,0,0,0,0,0,0);
        add(0,1,1,32'h04030201,1,32'hAABBCCDD,0, 1,0,1,0,0,0,0);
        add(0,0,1,32'h08070605,1,32'hAABBCCDD,1, 1,0,1,0,1,32'h04030201,0);
        add(0,0,0,32'hFFFFFFFF,0,0,0, 1,0,1,0,1,32'h08070605,0);
        add(0,0,1,32'h0C0B0A09,0,0,0, 1,0,1,0,0,32'h08070605,0);
        add(0,0,1,P,0,0,0, 1,0,1,0,1,32'h0C0B0A09,0);
        // bubbles
        add(0,1,1,32'h99999999,1,32'h04030201,0, 0,1,1,0,1,P,0);
        add(0,0,0,0,0,0,0, 0,1,1,0,0,P,32'h00000001);
        add(0,0,0,0,1,32'h08070605,1, 0,1,1,0,0,P,32'h00000200);
        add(0,1,0,0,0,0,0, 0,0,1,0,0,P,32'h00030005);
        add(0,0,0,0,1,32'h12345678,1, 0,0,1,0,0,P,32'h04000600);
        add(0,0,0,0,0,0,0, 0,0,1,0,0,P,32'h00070000);
        add(0,0,0,0,0,0,0, 0,0,1,0,0,P,32'h08000000);
        for (int k = 0; k < 4; k++) add(0,0,0,0,0,0,0, 0,0,1,0,0,P,0);
        // done cycle with start held
        add(0,1,0,0,0,0,0, 0,0,0,1,0,P,0);
        add(0,0,1,32'h01010101,0,0,0, 1,0,1,0,0,P,0);
        add(0,0,1,32'h02020202,0,0,0, 1,0,1,0,1,32'h01010101,0);
        add(0,0,1,32'h03030303,0,0,0, 1,0,1,0,1,32'h02020202,0);
        add(0,0,1,Q,0,0,0, 1,0,1,0,1,32'h03030303,0);
        // single vector skew and drain
        add(0,0,0,0,1,32'h44332211,1, 0,1,1,0,1,Q,0);
        add(0,0,0,0,0,0,0, 0,0,1,0,0,Q,32'h00000011);
        add(0,0,0,0,0,0,0, 0,0,1,0,0,Q,32'h00002200);
        add(0,0,0,0,0,0,0, 0,0,1,0,0,Q,32'h00330000);
        add(0,0,0,0,0,0,0, 0,0,1,0,0,Q,32'h44000000);
        for (int k = 0; k < 4; k++) add(0,0,0,0,0,0,0, 0,0,1,0,0,Q,0);
        add(0,0,0,0,0,0,0, 0,0,0,1,0,Q,0);
        // reset mid-job
        add(0,1,0,0,0,0,0, 0,0,0,0,0,Q,0);
        add(0,0,1,32'hA0A0A0A0,0,0,0, 1,0,1,0,0,Q,0);
        add(0,0,1,32'hB0B0B0B0,0,0,0, 1,0,1,0,1,32'hA0A0A0A0,0);
        add(0,0,1,32'hC0C0C0C0,0,0,0, 1,0,1,0,1,32'hB0B0B0B0,0);
        add(0,0,1,R,0,0,0, 1,0,1,0,1,32'hC0C0C0C0,0);
        add(0,0,0,0,1,32'h44332211,1, 0,1,1,0,1,R,0);
        add(0,0,0,0,0,0,0, 0,0,1,0,0,R,32'h00000011);
        add(1,0,0,0,0,0,0, 0,0,1,0,0,R,32'h00002200);
        add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        for (int k = 0; k < 6; k++) add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

        // reset with random inputs
        rst = 1'b1;
        start = 1'($urandom);
        w_valid = 1'($urandom);
        w_data = $urandom;
        a_valid = 1'($urandom);
        a_data = $urandom;
        a_last = 1'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 69'd0);

        for (int e = 0; e < tbl.size(); e++) begin
            @(negedge clk);
            check($sformatf("vec%0d", e),
                  {tbl[e].wr, tbl[e].ar, tbl[e].bz, tbl[e].dn,
                   tbl[e].we, tbl[e].upw, tbl[e].left});
            rst     = tbl[e].rst;
            start   = tbl[e].start;
            w_valid = tbl[e].wv;
            w_data  = tbl[e].wd;
            a_valid = tbl[e].av;
            a_data  = tbl[e].ad;
            a_last  = tbl[e].al;
        end

        // back-to-back job with random data and a bounded wait for done
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w_valid = 1'b1;
        wd_last = '0;
        for (int b = 0; b < 4; b++) begin
            wd_last = $urandom;
            w_data = wd_last;
            @(negedge clk);
        end
        vectors++;
        if (!(a_ready === 1'b1 && write_weight_en === 1'b1 &&
              out_up_weight === wd_last)) begin
            miscompares++;
            $display("FAIL job_stream_entry: ar=%b we=%b up=%h, want 1 1 %h",
                     a_ready, write_weight_en, out_up_weight, wd_last);
        end
        w_valid = 1'b0;
        ad_rand = $urandom;
        a_valid = 1'b1;
        a_data = ad_rand;
        a_last = 1'b1;
        n = 0;
        got_done = 1'b0;
        while (n < 30 && !got_done) begin
            @(negedge clk);
            a_valid = 1'b0;
            a_last = 1'b0;
            n++;
            if (n == 1) begin
                vectors++;
                if (out_left_act !== {24'd0, ad_rand[7:0]}) begin
                    miscompares++;
                    $display("FAIL job_lane0: got %h, want %h",
                             out_left_act, {24'd0, ad_rand[7:0]});
                end
            end
            if (done === 1'b1) got_done = 1'b1;
        end
        vectors++;
        if (!got_done || n != 9) begin
            miscompares++;
            $display("FAIL job_done_latency: got done=%b after %0d cycles, want done after 9",
                     got_done, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
